// File: rtl/alu_pkg.sv
// alu_pkg: shared integer-unit types and add/subtract mode encodings.
package alu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/multiword_add_sub_sequencer_if.sv
// multiword_add_sub_sequencer_if: operand/result handshake bundle of the multi-word add/sub sequencer.
interface multiword_add_sub_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WORDS  = 4
);
  logic                             in_valid;
  logic                             in_ready;
  logic                             mode;
  logic [DATA_WIDTH*NUM_WORDS-1:0]  operand_a;
  logic [DATA_WIDTH*NUM_WORDS-1:0]  operand_b;
  logic                             carry_in;
  logic                             out_valid;
  logic                             out_ready;
  logic [DATA_WIDTH*NUM_WORDS-1:0]  result;
  logic                             carry_out;
  logic                             overflow;
  logic                             busy;
  modport master (
    output in_valid, mode, operand_a, operand_b, carry_in, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, busy
  );
  modport slave (
    input  in_valid, mode, operand_a, operand_b, carry_in, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, busy
  );
endinterface

// File: rtl/word_add_slice.sv
// word_add_slice: one-word add/subtract with carry out and carry into the MSB.
module word_add_slice
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  mode,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout,
  output logic                  c_msb
);
  logic [DATA_WIDTH-1:0] bx;
  logic [DATA_WIDTH-1:0] lo;
  assign bx = (mode == MODE_SUB) ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, bx} + {{DATA_WIDTH{1'b0}}, cin};
  // Sum of the bits below the MSB; its top bit is the carry into the MSB.
  assign lo = {1'b0, a[DATA_WIDTH-2:0]} + {1'b0, bx[DATA_WIDTH-2:0]} + {{(DATA_WIDTH-1){1'b0}}, cin};
  assign c_msb = lo[DATA_WIDTH-1];
endmodule

// File: rtl/multiword_add_sub_sequencer.sv
// multiword_add_sub_sequencer: wide add/subtract processed one word per cycle, LSW first,
// with a registered carry chain between words.
module multiword_add_sub_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WORDS  = 4
) (
  input logic clk,
  input logic rst_n,
  multiword_add_sub_sequencer_if.slave bus
);
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);
  if (DATA_WIDTH < 2 || NUM_WORDS < 1) begin : g_bad_params
    $error("multiword_add_sub_sequencer: DATA_WIDTH must be >= 2 and NUM_WORDS >= 1");
  end
  seq_state_t state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] a_q, b_q, res_q;
  logic mode_q, c_q, cout_q, ovf_q;
  logic [DATA_WIDTH-1:0] sum;
  logic cout, c_msb, last;
  assign last = idx_q == LAST;
  word_add_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice (
    .a(a_q[idx_q]), .b(b_q[idx_q]), .mode(mode_q), .cin(c_q),
    .sum(sum), .cout(cout), .c_msb(c_msb)
  );
  always_comb begin
    state_d = (state_q == IDLE) ? (bus.in_valid ? RUN : IDLE) :
              (state_q == RUN)  ? (last ? DONE : RUN) :
                                  (bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      c_q     <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.in_valid) begin
        a_q    <= bus.operand_a;
        b_q    <= bus.operand_b;
        mode_q <= bus.mode;
        // Subtract runs as A + ~B + 1, so a borrow-in of 0 becomes a carry of 1.
        c_q    <= bus.carry_in ^ bus.mode;
        idx_q  <= '0;
      end
      if (state_q == RUN) begin
        res_q[idx_q] <= sum;
        c_q          <= cout;
        idx_q        <= last ? idx_q : idx_q + 1'b1;
        if (last) begin
          cout_q <= cout ^ mode_q;
          ovf_q  <= c_msb ^ cout;
        end
      end
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy      = state_q != IDLE;
  assign bus.result    = res_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_multiword_add_sub_sequencer.sv
// tb_multiword_add_sub_sequencer: random and directed ops on a 4x16 and a 1x8 instance vs an arithmetic model.
module tb_multiword_add_sub_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  multiword_add_sub_sequencer_if #(.DATA_WIDTH(16), .NUM_WORDS(4)) i64 ();
  multiword_add_sub_sequencer_if #(.DATA_WIDTH(8),  .NUM_WORDS(1)) i8 ();
  multiword_add_sub_sequencer #(.DATA_WIDTH(16), .NUM_WORDS(4)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(i64));
  multiword_add_sub_sequencer #(.DATA_WIDTH(8),  .NUM_WORDS(1)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(i8));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input int w, input logic m, input logic [63:0] a, input logic [63:0] b,
                                input logic c, output logic [63:0] r, output logic co, output logic ov);
    logic [64:0] f;
    logic [63:0] mask;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    a &= mask;
    b &= mask;
    f = m ? ({1'b0, a} - {1'b0, b} - 65'(c)) : ({1'b0, a} + {1'b0, b} + 65'(c));
    r = f[63:0] & mask;
    co = f[w];
    ov = m ? (a[w-1] != b[w-1] && r[w-1] != a[w-1]) : (a[w-1] == b[w-1] && r[w-1] != a[w-1]);
  endfunction

  task automatic drive(input bit s, input logic v, input logic m, input logic [63:0] a,
                       input logic [63:0] b, input logic c);
    if (s) begin
      i8.in_valid = v; i8.mode = m; i8.operand_a = a[7:0]; i8.operand_b = b[7:0]; i8.carry_in = c;
    end else begin
      i64.in_valid = v; i64.mode = m; i64.operand_a = a; i64.operand_b = b; i64.carry_in = c;
    end
  endtask

  task automatic set_ready(input bit s, input logic v);
    if (s) i8.out_ready = v; else i64.out_ready = v;
  endtask

  function automatic logic [63:0] res_of(input bit s);
    return s ? 64'(i8.result) : i64.result;
  endfunction

  // s selects the instance: 0 = 4x16, 1 = 1x8. hold = cycles out_ready stays low in DONE.
  task automatic op(input bit s, input logic m, input logic [63:0] a, input logic [63:0] b,
                    input logic c, input int hold);
    logic [63:0] er;
    logic eco, eov;
    int n;
    model(s ? 8 : 64, m, a, b, c, er, eco, eov);
    @(negedge clk);
    drive(s, 1'b1, m, a, b, c);
    @(posedge clk); #1;
    drive(s, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    check("busy_run", s ? i8.busy : i64.busy, 1);
    n = 0;
    while (!(s ? i8.out_valid : i64.out_valid) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), s ? 64'd1 : 64'd4);
    check("result", res_of(s), er);
    check("carry_out", s ? i8.carry_out : i64.carry_out, eco);
    check("overflow", s ? i8.overflow : i64.overflow, eov);
    check("in_ready_done", s ? i8.in_ready : i64.in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      drive(s, 1'b1, ~m, ~a, ~b, ~c);
      @(posedge clk); #1;
      check("hold_valid", s ? i8.out_valid : i64.out_valid, 1);
      check("hold_result", res_of(s), er);
      check("hold_flags", s ? {i8.carry_out, i8.overflow} : {i64.carry_out, i64.overflow}, {eco, eov});
      check("hold_in_ready", s ? i8.in_ready : i64.in_ready, 0);
    end
    set_ready(s, 1'b1);
    @(posedge clk); #1;
    set_ready(s, 1'b0);
    drive(s, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    check("release_idle", s ? {i8.in_ready, i8.out_valid, i8.busy} : {i64.in_ready, i64.out_valid, i64.busy}, 3'b100);
  endtask

  initial begin
    logic [63:0] ra, rb;
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    set_ready(0, 1'b0);
    set_ready(1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", {i64.in_ready, i8.in_ready}, 2'b11);
    check("rst_outs", {i64.out_valid, i64.carry_out, i64.overflow, i64.busy}, 4'b0);
    check("rst_result", i64.result, 64'd0);
    op(0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 0);
    op(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
    op(0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
    op(0, 1'b1, 64'd0, 64'd1, 1'b0, 0);
    op(0, 1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 0);
    op(0, 1'b1, 64'd5, 64'd3, 1'b1, 0);
    op(0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 10);
    op(0, 1'b1, 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 1'b0, 0);
    // Abort an op two RUN cycles in with a one-edge reset.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_state", {i64.in_ready, i64.out_valid, i64.busy}, 3'b100);
    check("abort_result", i64.result, 64'd0);
    repeat (4) @(posedge clk);
    #1 check("abort_no_valid", i64.out_valid, 0);
    op(0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 0);
    op(1, 1'b0, 64'h7F, 64'h01, 1'b0, 0);
    op(1, 1'b1, 64'h00, 64'h01, 1'b0, 2);
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      op(i % 2 == 1, 1'($urandom), ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
